// File: rtl/carwash_pkg.sv
// Shared definitions for the car-wash sequencer: step codes, program encoding,
// FSM state encoding and small select-decoding helpers.
package carwash_pkg;

    // Step codes as consumed by the seven-segment display decoder
    localparam logic [3:0] STEP_IDLE    = 4'd0;
    localparam logic [3:0] STEP_PB      = 4'd1;
    localparam logic [3:0] STEP_PE      = 4'd2;
    localparam logic [3:0] STEP_PP      = 4'd3;
    localparam logic [3:0] STEP_SCRUB_A = 4'd4;
    localparam logic [3:0] STEP_FOAM    = 4'd5;
    localparam logic [3:0] STEP_PRESOAK = 4'd6;
    localparam logic [3:0] STEP_SCRUB   = 4'd7;
    localparam logic [3:0] STEP_RINSE   = 4'd8;
    localparam logic [3:0] STEP_END     = 4'd9;
    localparam logic [3:0] STEP_WAX     = 4'd10;
    localparam logic [3:0] STEP_SCRUB_B = 4'd11;
    localparam logic [3:0] STEP_RINSE_B = 4'd12;
    localparam logic [3:0] STEP_DRY     = 4'd13;
    localparam logic [3:0] STEP_SHIELD  = 4'd14;
    localparam logic [3:0] STEP_SHINE   = 4'd15;

    typedef enum logic [1:0] {
        PROG_BASIC = 2'd0,
        PROG_EXTRA = 2'd1,
        PROG_PLAT  = 2'd2
    } prog_t;

    // FSM state encoding kept as plain constants for legacy tooling
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_SHOW  = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_END   = 3'd4;

    function automatic logic is_onehot3(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    endfunction

    // Only meaningful when sel is one-hot
    function automatic prog_t sel_to_prog(input logic [2:0] sel);
        prog_t p;
        case (sel)
            3'b010:  p = PROG_EXTRA;
            3'b100:  p = PROG_PLAT;
            default: p = PROG_BASIC;
        endcase
        return p;
    endfunction

    // Code shown during SHOW identifies the selected program
    function automatic logic [3:0] show_code(input prog_t p);
        logic [3:0] c;
        case (p)
            PROG_EXTRA: c = STEP_PE;
            PROG_PLAT:  c = STEP_PP;
            default:    c = STEP_PB;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/carwash_prog_rom.sv
// Program ROM: maps (program, RUN index) to a step code and a last-step flag.
// SHOW and END codes are not stored here; the index covers the RUN steps only.
module carwash_prog_rom
    import carwash_pkg::*;
(
    input  prog_t      i_prog,
    input  logic [3:0] i_index,
    output logic [3:0] o_code,
    output logic       o_last
);

    // Combinational lookup; unused indices map to IDLE and force the exit to END
    always_comb begin
        o_code = STEP_IDLE;
        o_last = 1'b1;
        case (i_prog)
            PROG_BASIC: begin
                case (i_index)
                    4'd0:    begin o_code = STEP_FOAM;  o_last = 1'b0; end
                    4'd1:    begin o_code = STEP_SCRUB; o_last = 1'b0; end
                    4'd2:    begin o_code = STEP_RINSE; o_last = 1'b1; end
                    default: begin o_code = STEP_IDLE;  o_last = 1'b1; end
                endcase
            end
            PROG_EXTRA: begin
                case (i_index)
                    4'd0:    begin o_code = STEP_PRESOAK; o_last = 1'b0; end
                    4'd1:    begin o_code = STEP_SCRUB;   o_last = 1'b0; end
                    4'd2:    begin o_code = STEP_FOAM;    o_last = 1'b0; end
                    4'd3:    begin o_code = STEP_SCRUB_A; o_last = 1'b0; end
                    4'd4:    begin o_code = STEP_RINSE;   o_last = 1'b1; end
                    default: begin o_code = STEP_IDLE;    o_last = 1'b1; end
                endcase
            end
            PROG_PLAT: begin
                case (i_index)
                    4'd0:    begin o_code = STEP_PRESOAK; o_last = 1'b0; end
                    4'd1:    begin o_code = STEP_SCRUB;   o_last = 1'b0; end
                    4'd2:    begin o_code = STEP_FOAM;    o_last = 1'b0; end
                    4'd3:    begin o_code = STEP_SCRUB_A; o_last = 1'b0; end
                    4'd4:    begin o_code = STEP_RINSE;   o_last = 1'b0; end
                    4'd5:    begin o_code = STEP_WAX;     o_last = 1'b0; end
                    4'd6:    begin o_code = STEP_SCRUB_B; o_last = 1'b0; end
                    4'd7:    begin o_code = STEP_RINSE_B; o_last = 1'b0; end
                    4'd8:    begin o_code = STEP_DRY;     o_last = 1'b0; end
                    4'd9:    begin o_code = STEP_SHIELD;  o_last = 1'b0; end
                    4'd10:   begin o_code = STEP_SHINE;   o_last = 1'b1; end
                    default: begin o_code = STEP_IDLE;    o_last = 1'b1; end
                endcase
            end
            default: begin
                o_code = STEP_IDLE;
                o_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/carwash_sequencer.sv
// Car-wash step sequencer: takes payment and a one-hot program select, then
// walks the display step code through the program with a fixed dwell per step.
// Optional feature macro: CARWASH_PAUSE_EN adds a 'pause' input that freezes
// the step timing while a wash is in progress.
module carwash_sequencer
    import carwash_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned STEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pay,
    input  logic       start,
    input  logic       abort,
`ifdef CARWASH_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [2:0] prog_sel,
    output logic [3:0] step_code,
    output logic       busy,
    output logic       credit,
    output logic       done,
    output logic       err
);

    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned DWELL_W = $clog2(STEP_TICKS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP_TICKS - 1);

    state_t              r_state;
    prog_t               r_prog;
    logic [3:0]          r_index;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic                r_pay_q;
    logic                r_start_q;
    logic                r_done;
    logic                r_err;

    state_t              w_state_nxt;
    prog_t               w_prog_nxt;
    logic [3:0]          w_index_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [DWELL_W-1:0]  w_dwell_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_pay_rise;
    logic                w_start_rise;
    logic                w_active;
    logic                w_hold;
    logic                w_adv_en;
    logic                w_tick;
    logic                w_step_done;
    logic [3:0]          w_rom_code;
    logic                w_rom_last;

    assign w_pay_rise   = pay & ~r_pay_q;
    assign w_start_rise = start & ~r_start_q;
    assign w_active     = (r_state == ST_SHOW) || (r_state == ST_RUN) || (r_state == ST_END);

`ifdef CARWASH_PAUSE_EN
    assign w_hold = pause;
`else
    assign w_hold = 1'b0;
`endif

    assign w_adv_en    = w_active & ~w_hold;
    assign w_tick      = w_adv_en && (r_tick_cnt == TICK_LAST);
    assign w_step_done = w_tick && (r_dwell_cnt == DWELL_LAST);

    carwash_prog_rom u_rom (
        .i_prog  (r_prog),
        .i_index (r_index),
        .o_code  (w_rom_code),
        .o_last  (w_rom_last)
    );

    // Tick/dwell timing: runs only while a wash is active and not held
    always_comb begin
        w_tick_nxt  = r_tick_cnt;
        w_dwell_nxt = r_dwell_cnt;
        if (!w_active || abort) begin
            w_tick_nxt  = '0;
            w_dwell_nxt = '0;
        end else if (w_adv_en) begin
            w_tick_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                w_dwell_nxt = (r_dwell_cnt == DWELL_LAST) ? '0 : r_dwell_cnt + 1'b1;
            end
        end
    end

    // FSM next state, program latch, step index and event pulses
    always_comb begin
        w_state_nxt = r_state;
        w_prog_nxt  = r_prog;
        w_index_nxt = r_index;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start arriving with the pay edge is deliberately dropped
                if (w_pay_rise) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_start_rise) begin
                    if (is_onehot3(prog_sel)) begin
                        w_prog_nxt  = sel_to_prog(prog_sel);
                        w_index_nxt = 4'd0;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                if (w_step_done) begin
                    w_index_nxt = 4'd0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_step_done) begin
                    if (w_rom_last) w_state_nxt = ST_END;
                    else            w_index_nxt = r_index + 4'd1;
                end
            end
            ST_END: begin
                if (w_step_done) begin
                    w_index_nxt = 4'd0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_index_nxt = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort overrides every other event, including a same-cycle done
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = 4'd0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prog      <= PROG_BASIC;
            r_index     <= 4'd0;
            r_tick_cnt  <= '0;
            r_dwell_cnt <= '0;
            r_pay_q     <= 1'b0;
            r_start_q   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prog      <= w_prog_nxt;
            r_index     <= w_index_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_pay_q     <= pay;
            r_start_q   <= start;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Display code decoded from the current state
    always_comb begin
        step_code = STEP_IDLE;
        case (r_state)
            ST_SHOW: step_code = show_code(r_prog);
            ST_RUN:  step_code = w_rom_code;
            ST_END:  step_code = STEP_END;
            default: step_code = STEP_IDLE;
        endcase
    end

    assign busy   = w_active;
    assign credit = (r_state == ST_ARMED);
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_carwash_sequencer.sv
// Directed self-checking bench for carwash_sequencer (TICK_DIV=4, STEP_TICKS=2,
// so every step lasts 8 clocks). Outputs are sampled 1 time unit after posedge.
module tb_carwash_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pay = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] prog_sel = 3'b000;
`ifdef CARWASH_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [3:0] step_code;
    logic       busy;
    logic       credit;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Sequences packed one code per nibble, first code in the low nibble
    logic [63:0] seq_basic = 64'h98751;
    logic [63:0] seq_extra = 64'h9845762;
    logic [63:0] seq_plat  = 64'h9FEDCBA845763;

    always #5 clk = ~clk;

    carwash_sequencer #(
        .TICK_DIV   (4),
        .STEP_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pay       (pay),
        .start     (start),
        .abort     (abort),
`ifdef CARWASH_PAUSE_EN
        .pause     (pause),
`endif
        .prog_sel  (prog_sel),
        .step_code (step_code),
        .busy      (busy),
        .credit    (credit),
        .done      (done),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in ARMED
    task automatic give_credit();
        pay = 1'b1;
        step_clk();
        pay = 1'b0;
        step_clk();
    endtask

    // Returns during the first SHOW cycle
    task automatic begin_wash(input logic [2:0] sel);
        prog_sel = sel;
        start    = 1'b1;
        step_clk();
        start    = 1'b0;
    endtask

    task automatic run_seq(input logic [63:0] s, input int len, input string tag);
        logic [3:0] code;
        for (int i = 0; i < len; i++) begin
            code = s[i*4 +: 4];
            for (int c = 0; c < 8; c++) begin
                check_eq(tag, 32'(step_code), 32'(code));
                if (c == 0) begin
                    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                    check_eq({tag, "_nodone"}, 32'(done), 32'd0);
                end
                step_clk();
            end
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_code_after"}, 32'(step_code), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_credit_after"}, 32'(credit), 32'd0);
        step_clk();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int done_cnt;

        // Reset state
        step_clk();
        check_eq("rst_code", 32'(step_code), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_credit", 32'(credit), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step_clk();

        // Basic run
        give_credit();
        check_eq("basic_credit", 32'(credit), 32'd1);
        check_eq("basic_armed_code", 32'(step_code), 32'd0);
        begin_wash(3'b001);
        run_seq(seq_basic, 5, "basic");

        // Platinum run
        give_credit();
        begin_wash(3'b100);
        run_seq(seq_plat, 13, "plat");

        // Invalid select, then a valid extra run
        give_credit();
        prog_sel = 3'b011;
        start    = 1'b1;
        step_clk();
        start    = 1'b0;
        check_eq("inv_err", 32'(err), 32'd1);
        check_eq("inv_credit", 32'(credit), 32'd1);
        check_eq("inv_code", 32'(step_code), 32'd0);
        check_eq("inv_busy", 32'(busy), 32'd0);
        step_clk();
        check_eq("inv_err_pulse", 32'(err), 32'd0);
        check_eq("inv_credit_kept", 32'(credit), 32'd1);
        begin_wash(3'b010);
        run_seq(seq_extra, 7, "extra");

        // Abort on the third cycle of the foam step
        give_credit();
        begin_wash(3'b001);
        repeat (8) step_clk();
        check_eq("abort_foam", 32'(step_code), 32'd5);
        step_clk();
        step_clk();
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        check_eq("abort_code", 32'(step_code), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_credit", 32'(credit), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            step_clk();
        end
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_eq("abort_start_busy", 32'(busy), 32'd0);
        check_eq("abort_start_credit", 32'(credit), 32'd0);
        step_clk();
        check_eq("abort_start_busy2", 32'(busy), 32'd0);

        // Simultaneous pay+start, held start, pay during a run
        prog_sel = 3'b001;
        pay      = 1'b1;
        start    = 1'b1;
        step_clk();
        check_eq("edge_both_credit", 32'(credit), 32'd1);
        check_eq("edge_both_busy", 32'(busy), 32'd0);
        repeat (3) step_clk();
        check_eq("edge_held_credit", 32'(credit), 32'd1);
        check_eq("edge_held_busy", 32'(busy), 32'd0);
        pay   = 1'b0;
        start = 1'b0;
        step_clk();
        begin_wash(3'b001);
        check_eq("edge_run_busy", 32'(busy), 32'd1);
        repeat (12) step_clk();
        pay = 1'b1;
        step_clk();
        pay = 1'b0;
        check_eq("edge_pay_run_credit", 32'(credit), 32'd0);
        check_eq("edge_pay_run_busy", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            step_clk();
            n++;
        end
        check_eq("edge_done_seen", 32'(done), 32'd1);
        check_eq("edge_done_credit", 32'(credit), 32'd0);
        step_clk();
        check_eq("edge_after_credit", 32'(credit), 32'd0);
        check_eq("edge_after_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-platinum
        give_credit();
        begin_wash(3'b100);
        repeat (30) step_clk();
        check_eq("areset_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_code", 32'(step_code), 32'd0);
        check_eq("areset_busy", 32'(busy), 32'd0);
        check_eq("areset_credit", 32'(credit), 32'd0);
        check_eq("areset_done", 32'(done), 32'd0);
        check_eq("areset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step_clk();
        check_eq("areset_idle_busy", 32'(busy), 32'd0);
        check_eq("areset_idle_credit", 32'(credit), 32'd0);
        check_eq("areset_idle_code", 32'(step_code), 32'd0);
        give_credit();
        check_eq("areset_pay_credit", 32'(credit), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carwash_sequencer.md
Name: carwash_sequencer

Overview:
Timed controller for the car-wash step display datapath. It accepts payment and a program selection, then steps the 4-bit wash step code (the same 0..15 encoding the seven-segment display decoder consumes) through the selected program, dwelling a fixed time on each step. It replaces manual per-step button advancing with an autonomous, abortable sequence. It sits between the debounced board inputs and the display decoder.

Parameters:
TICK_DIV, 50_000_000, clk cycles per timer tick (1 s at 50 MHz); minimum 2
STEP_TICKS, 3, ticks spent on each displayed step; minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pay  in  1  payment button, already synchronised and debounced, level
start  in  1  start button, synchronised and debounced, level
abort  in  1  abort/clear, level, highest priority
prog_sel  in  3  [0]=basic, [1]=extra, [2]=platinum; must be one-hot at start
step_code  out  4  current step code to the display decoder
busy  out  1  high in SHOW, RUN and END
credit  out  1  high in ARMED
done  out  1  one-cycle pulse when a wash completes normally
err  out  1  one-cycle pulse on start with non-one-hot prog_sel

Behaviour:
- Reset: state IDLE, step_code=0, busy=credit=done=err=0, step index=0, tick and dwell counters=0.
- Inputs are synchronous. pay and start act on their rising edge; their edge registers also reset to 0.
- FSM:
  - IDLE: step_code=0. A pay edge moves to ARMED.
  - ARMED: step_code=0 and credit=1. On a start edge:
    - if prog_sel is one-hot, latch the program, clear the tick and dwell counters, and go to SHOW;
    - otherwise pulse err and stay in ARMED.
  - SHOW: step_code is 1, 2 or 3 for basic, extra or platinum.
  - RUN: step_code = rom(program, index).
  - END: step_code=9. On dwell expiry, go to IDLE and pulse done in the same cycle as the transition.
- Step sequences, including SHOW and END:
  - basic: 1,5,7,8,9
  - extra: 2,6,7,5,4,8,9
  - platinum: 3,6,7,5,4,8,10,11,12,13,14,15,9
- Timing:
  - step_code changes on the clock after the accepting start edge (1-cycle latency).
  - Each step lasts exactly STEP_TICKS*TICK_DIV cycles.
  - When the tick counter reaches TICK_DIV-1 it wraps to 0 and asserts tick. A dwell counter counts ticks up to STEP_TICKS-1, then advances the step.
- Step advance: from SHOW go to RUN with index 0. In RUN, the rom's last flag moves the FSM to END; otherwise the index increments.
- Boundary conditions:
  - abort=1 in any state: IDLE on the next clock, credit lost, counters cleared, no done pulse. Abort wins over every simultaneous event.
  - pay and start rising together in IDLE: pay is accepted and start ignored; a fresh start edge is needed.
  - pay during SHOW, RUN or END is ignored (no credit stacking).
  - start outside ARMED is ignored. prog_sel changes after latching are ignored.
  - A held start or pay does not retrigger.
  - Async reset mid-wash returns everything to reset values immediately.
- Widths: the step index is 4 bits. The tick counter is $clog2(TICK_DIV) bits and the dwell counter $clog2(STEP_TICKS+1) bits, with no overflow beyond the stated terminal counts.

Optional Feature:
CARWASH_PAUSE_EN:
- Defined: adds input pause (1 bit). While pause=1 in SHOW, RUN or END, the tick and dwell counters freeze and step_code is held. Timing resumes exactly where it stopped. abort still overrides pause.
- Undefined: there is no pause port and the sequence is never held.

Decomposition:
- Package carwash_pkg holds:
  - the step-code localparams STEP_IDLE=0, STEP_PB=1, STEP_PE=2, STEP_PP=3, STEP_SCRUB_A=4, STEP_FOAM=5, STEP_PRESOAK=6, STEP_SCRUB=7, STEP_RINSE=8, STEP_END=9, STEP_WAX=10, STEP_SCRUB_B=11, STEP_RINSE_B=12, STEP_DRY=13, STEP_SHIELD=14, STEP_SHINE=15;
  - the program enum PROG_BASIC/PROG_EXTRA/PROG_PLAT (2 bits);
  - the FSM state typedef.
- Sub-module carwash_prog_rom: combinational lookup (program, index) -> step code and last flag.

Test Plan:
All scenarios use TICK_DIV=4, STEP_TICKS=2, so each step lasts 8 cycles.
- Basic run: pay, prog_sel=001, start -> step_code 1,5,7,8,9 for 8 cycles each, then one done pulse, step_code=0, busy=0.
- Platinum run: pay, prog_sel=100, start -> 13 codes 3,6,7,5,4,8,10,11,12,13,14,15,9 over 104 cycles, then done.
- Invalid select: pay, prog_sel=011, start -> err pulse, credit stays 1, step_code=0. Then prog_sel=010 with a new start edge -> extra sequence 2,6,7,5,4,8,9.
- Abort: abort asserted on cycle 3 of the foam step of a basic run -> step_code=0 on the next clock, busy=0, credit=0, no done. A start alone then does nothing.
- Edge rules: pay and start rising together in IDLE -> ARMED only. A held start does not begin a wash. A second pay during RUN leaves credit=0 after done.
- Reset: rst_n low mid-platinum run -> all outputs 0 with no clock edge; after release, the block idles until a pay edge.
